// File: rtl/encoder8to3_seq_pkg.sv
// encoder8to3_seq_pkg
// Shared constants and helpers for the registered 8-to-3 request encoder.
//   IDX_W    : width of the encoded index
//   N_REQ    : number of request lines
//   prio_sel : highest-priority set bit of a request vector
//   onehot8  : index -> one-hot request mask
package encoder8to3_seq_pkg;

  localparam int IDX_W = 3;
  localparam int N_REQ = 8;

  // high_first=1: bit 7 wins; high_first=0: bit 0 wins.
  // Returns 0 when r is empty; callers qualify with r != 0.
  function automatic logic [IDX_W-1:0] prio_sel(input logic [N_REQ-1:0] r,
                                                input logic high_first);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (high_first) begin
      // Ascending scan: the last set bit seen is the highest one.
      for (int i = 0; i < N_REQ; i++) begin
        if (r[i]) idx = IDX_W'(i);
      end
    end else begin
      // Descending scan: the last set bit seen is the lowest one.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (r[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/encoder8to3_seq_if.sv
// encoder8to3_seq_if
// Request/index bus of the 8-to-3 encoder.
//   D0..D7  : request lines (level, sampled every clock)
//   ACK     : consumer accepts the presented index
//   A,B,C   : presented index, A = MSB
//   V       : index valid
//   MORE    : further requests pending beyond the presented one
//
// Handshake: an index is transferred on a rising edge where V=1 and ACK=1.
// While V=1 and ACK=0 the index and V stay stable. ACK with V=0 has no
// effect. V may drop only after a transfer (nothing left to present).
//
// Modports: master = request source / index consumer, slave = encoder.
interface encoder8to3_seq_if;

  logic D0, D1, D2, D3, D4, D5, D6, D7;
  logic ACK;
  logic A, B, C;
  logic V;
  logic MORE;

  modport master (
    output D0, D1, D2, D3, D4, D5, D6, D7, ACK,
    input  A, B, C, V, MORE
  );

  modport slave (
    input  D0, D1, D2, D3, D4, D5, D6, D7, ACK,
    output A, B, C, V, MORE
  );

endinterface

// File: rtl/encoder8to3_seq_prio_enc8.sv
// prio_enc8
// Combinational 8-input priority encoder.
//   r          : request vector
//   high_first : 1 -> bit 7 highest priority, 0 -> bit 0 highest priority
//   idx        : index of the winning bit (0 when r is empty)
//   any        : r has at least one bit set
module prio_enc8
  import encoder8to3_seq_pkg::*;
(
  input  logic [N_REQ-1:0] r,
  input  logic             high_first,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  assign idx = prio_sel(r, high_first);
  assign any = |r;

endmodule

// File: rtl/encoder8to3_seq.sv
// encoder8to3_seq
// Registered 8-to-3 encoder with request latching. Requests are merged into
// a pending register; one pending index at a time is presented with a
// valid flag and its pending bit is cleared when the index is loaded.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : encoder8to3_seq_if.slave (D0..D7, ACK in; A,B,C, V, MORE out)
// Parameter HIGH_FIRST: 1 -> D7 highest priority, 0 -> D0 highest priority.
module encoder8to3_seq
  import encoder8to3_seq_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  encoder8to3_seq_if.slave    bus
);

  logic [N_REQ-1:0] pend_q;
  logic [IDX_W-1:0] abc_q;
  logic             v_q;
  logic             more_q;

  logic [N_REQ-1:0] d_vec;
  logic [N_REQ-1:0] r_vec;
  logic             load;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [N_REQ-1:0] r_after_load;
  logic [N_REQ-1:0] r_after_hold;

  assign d_vec = {bus.D7, bus.D6, bus.D5, bus.D4,
                  bus.D3, bus.D2, bus.D1, bus.D0};

  // New requests merge with pending ones; a level held for several cycles
  // collapses into a single pending bit.
  assign r_vec = pend_q | d_vec;

  // A new index may be loaded when nothing is presented or the current one
  // is being accepted. ACK while V=0 therefore changes nothing extra.
  assign load = ~v_q | bus.ACK;

  prio_enc8 u_prio (
    .r          (r_vec),
    .high_first (HIGH_FIRST),
    .idx        (sel_idx),
    .any        (sel_any)
  );

  assign r_after_load = r_vec & ~onehot8(sel_idx);
  // While presenting, a repeat request on the presented line is absorbed
  // rather than re-pended.
  assign r_after_hold = r_vec & ~onehot8(abc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      abc_q  <= '0;
      v_q    <= 1'b0;
      more_q <= 1'b0;
    end else if (load) begin
      if (sel_any) begin
        abc_q  <= sel_idx;
        v_q    <= 1'b1;
        pend_q <= r_after_load;
        more_q <= |r_after_load;
      end else begin
        // abc_q intentionally keeps its last value; it is don't-care at V=0.
        v_q    <= 1'b0;
        more_q <= 1'b0;
        pend_q <= '0;
      end
    end else begin
      // Holding: index and V stay put; priority is only resolved at load.
      pend_q <= r_after_hold;
      more_q <= |r_after_hold;
    end
  end

  assign bus.A    = abc_q[2];
  assign bus.B    = abc_q[1];
  assign bus.C    = abc_q[0];
  assign bus.V    = v_q;
  assign bus.MORE = more_q;

endmodule
